// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder/subtractor.
//   op_t    : operation select (OP_ADD / OP_SUB)
//   flags_t : registered result flags {cout, ovf, zero}
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational N-bit ripple-carry adder segment built from per-bit
// full-adder equations.
//   a, b : N-bit operands
//   cin  : carry into bit 0
//   sum  : N-bit sum
//   cout : carry out of bit N-1
module adder_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[N];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
// registered segments of CHUNK = WIDTH/STAGES bits; stage k resolves chunk k.
// WIDTH must be a multiple of STAGES.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, cin, op        : operands; cin is borrow-in on subtract
//   out_valid / out_ready: result handshake
//   sum, cout, ovf, zero : result and registered flags
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Per-stage pipeline registers. Each stage carries the full operand words
  // forward so the upper chunks (and the MSBs needed for overflow) reach the
  // stage that consumes them; sum bits fill in from the bottom.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             v_q [STAGES];
  logic             v_d [STAGES];
  flags_t           flags_q;
  flags_t           flags_d;

  // Inputs seen by each stage: stage 0 from the ports, others from k-1.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic [CHUNK-1:0] chunk_sum  [STAGES];
  logic             chunk_cout [STAGES];
  logic [WIDTH-1:0] s_new      [STAGES];

  logic adv;

  // Whole pipe moves together: it advances unless a result is stuck at the
  // output. Bubbles are held too, which keeps the logic a single enable.
  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = adv;

  always_comb begin : stage_inputs
    a_in[0] = a;
    // Subtract as a + ~b + !borrow_in.
    b_in[0] = (op == OP_SUB) ? ~b : b;
    c_in[0] = (op == OP_SUB) ? ~cin : cin;
    v_in[0] = in_valid;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    adder_slice #(
      .N(CHUNK)
    ) u_slice (
      .a   (a_in[g][g*CHUNK +: CHUNK]),
      .b   (b_in[g][g*CHUNK +: CHUNK]),
      .cin (c_in[g]),
      .sum (chunk_sum[g]),
      .cout(chunk_cout[g])
    );
  end

  always_comb begin : stage_next
    for (int k = 0; k < STAGES; k++) begin
      s_new[k]                    = s_in[k];
      s_new[k][k*CHUNK +: CHUNK]  = chunk_sum[k];
      if (adv) begin
        a_d[k] = a_in[k];
        b_d[k] = b_in[k];
        s_d[k] = s_new[k];
        c_d[k] = chunk_cout[k];
        v_d[k] = v_in[k];
      end else begin
        a_d[k] = a_q[k];
        b_d[k] = b_q[k];
        s_d[k] = s_q[k];
        c_d[k] = c_q[k];
        v_d[k] = v_q[k];
      end
    end

    // Flags are registered alongside the final sum so they reset to 0
    // rather than reflecting an all-zero sum.
    flags_d = flags_q;
    if (adv) begin
      flags_d.cout = chunk_cout[LAST];
      flags_d.ovf  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                     (s_new[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
      flags_d.zero = ~|s_new[LAST];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      flags_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      flags_q <= flags_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;
  import adder_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    logic             z;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  op_t              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  logic rnd_mode = 1'b0;
  logic ov_hist [0:4095];
  exp_t sb [$];

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference from integer arithmetic, independent of the carry-chain form.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mcin, input op_t mop);
    exp_t   e;
    longint ur;
    longint sr;
    if (mop == OP_ADD) begin
      ur  = longint'(ma) + longint'(mb) + longint'(mcin);
      sr  = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mcin);
      e.c = ur[32];
    end else begin
      ur  = longint'(ma) - longint'(mb) - longint'(mcin);
      sr  = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mcin);
      e.c = (ur >= 0);
    end
    e.s = ur[31:0];
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z = (e.s == '0);
    return e;
  endfunction

  // Scoreboard monitor: samples at negedge, pops on every completed handshake.
  initial begin : monitor
    exp_t e;
    exp_t cur;
    exp_t held;
    logic stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      ov_hist[cyc % 4096] = out_valid;
      if (rst) begin
        stall_prev = 1'b0;
      end else if (out_valid) begin
        cur = {sum, cout, ovf, zero};
        if (stall_prev) check("stall_hold", 64'(cur), 64'(held));
        if (!out_ready) begin
          check("in_ready_stall", 64'(in_ready), 64'd0);
          held = cur;
          stall_prev = 1'b1;
        end else begin
          stall_prev = 1'b0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output got=%0h want=none (t=%0t)", cur, $time);
          end else begin
            e = sb.pop_front();
            check("result", 64'(cur), 64'(e));
          end
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sbv,
                      input logic scin, input op_t sop, input exp_t e);
    bit accepted;
    int n;
    accepted = 1'b0;
    n = 0;
    a = sa;
    b = sbv;
    cin = scin;
    op = sop;
    in_valid = 1'b1;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        acc_cyc = cyc + 1;
        accepted = 1'b1;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic wait_latency(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    // Edges from acceptance to the edge that raises out_valid.
    check(name, 64'(cyc - acc_cyc), 64'(STAGES - 1));
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=0", sb.size());
    end
  endtask

  initial begin : stimulus
    int pat [9];
    int c0;
    exp_t e;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;
    op_t  ro;

    pat = '{1, 0, 1, 1, 1, 0, 0, 0, 0};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    op = OP_ADD;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", 64'({sum, cout, ovf, zero}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: basic add and latency
    send(32'h0000_0001, 32'h0000_0001, 1'b0, OP_ADD, '{32'h0000_0002, 1'b0, 1'b0, 1'b0});
    wait_latency("latency_first");
    drain();

    // 2, 3: full carry ripple, overflow, subtract
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, OP_ADD, '{32'h0000_0000, 1'b1, 1'b0, 1'b1});
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    send(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    send(32'h0000_0003, 32'h0000_0005, 1'b0, OP_SUB, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    send(32'h0000_0005, 32'h0000_0005, 1'b0, OP_SUB, '{32'h0000_0000, 1'b1, 1'b0, 1'b1});
    drain();

    // 4: back-pressure with random beats
    rnd_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      ro = op_t'($urandom_range(0, 1));
      send(ra, rb, rc, ro, model(ra, rb, rc, ro));
    end
    drain();
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    tick();

    // 5: bubbles at full throughput
    c0 = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = pat[i][0];
      a = 32'(i * 3);
      b = 32'(i + 100);
      cin = 1'b0;
      op = OP_ADD;
      @(negedge clk);
      if (i == 0) c0 = cyc;
      if (pat[i] != 0 && in_ready) sb.push_back(model(32'(i * 3), 32'(i + 100), 1'b0, OP_ADD));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("bubble_pattern_%0d", i), 64'(ov_hist[(c0 + i + 4) % 4096]), 64'(pat[i]));
    end
    drain();

    // 6: mid-stream reset
    send(32'h0000_0010, 32'h0000_0020, 1'b0, OP_ADD, model(32'h10, 32'h20, 1'b0, OP_ADD));
    send(32'h0000_0011, 32'h0000_0021, 1'b0, OP_ADD, model(32'h11, 32'h21, 1'b0, OP_ADD));
    send(32'h0000_0012, 32'h0000_0022, 1'b0, OP_ADD, model(32'h12, 32'h22, 1'b0, OP_ADD));
    send(32'h0000_0013, 32'h0000_0023, 1'b0, OP_ADD, model(32'h13, 32'h23, 1'b0, OP_ADD));
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", 64'({sum, cout, ovf, zero}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    send(32'h0000_000A, 32'h0000_0003, 1'b1, OP_SUB, '{32'h0000_0006, 1'b1, 1'b0, 1'b0});
    wait_latency("latency_after_reset");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined WIDTH-bit adder/subtractor for the datapath ALU. It is the successor of the fixed 4-bit ripple-carry adder. The carry chain is split into STAGES registered segments of CHUNK = WIDTH/STAGES bits each. Operands enter through a valid/ready handshake, and one result per cycle leaves with carry, signed-overflow and zero flags.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry segments; range 1..WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in on add, borrow-in on subtract.
- op  in  1  adder_pkg::op_t: OP_ADD=0, OP_SUB=1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1; on subtract, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Operation results:
  - OP_ADD: {cout,sum} = a + b + cin.
  - OP_SUB: {cout,sum} = a + ~b + !cin, i.e. a − b − cin with inverted borrow.
- Operand conditioning at entry: b_eff = op ? ~b : b; c0 = op ? !cin : cin.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff with the carry registered by stage k−1 (c0 for stage 0).
  - It registers the chunk sum, its carry-out, all lower sum chunks, and the still-unused upper operand chunks.
  - It also registers one valid bit.
- Final stage computes:
  - ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]); the operand MSBs travel down the pipe to feed this.
  - zero = ~|sum.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Flow control uses a global advance: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - When adv=1, every stage loads from its predecessor and stage 0 loads {in_valid, operands}.
  - When adv=0, every stage holds, including bubbles.
- A beat is accepted iff in_valid && in_ready at the clock edge.
- in_valid=0 while adv=1 injects a bubble (valid=0).
- STAGES=1 degenerates to a single registered full-width adder.

## Timing
- Reset (async, immediate): all stage valids, out_valid, sum, cout, ovf and zero go to 0. in_ready therefore reads 1 while rst is high and after release.
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+STAGES−1 and is visible during cycle T+STAGES. With no stall, that is exactly STAGES cycles from acceptance to output.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 forces in_ready=0 in the same cycle.
  - sum and flags hold stable until the handshake completes.
  - No beat is lost or duplicated.
- out_valid=1 && out_ready=1 && in_valid=1 in the same cycle: the result retires, the pipe shifts, and the new beat is accepted.
- Reset asserted mid-stream discards all in-flight beats. The first post-reset output is the first beat accepted after release.
- Inputs a, b, cin and op are sampled only on acceptance and may change freely otherwise.

## Structure
- Package adder_pkg holds:
  - typedef enum logic {OP_ADD, OP_SUB} op_t;
  - typedef struct packed {cout, ovf, zero} flags_t.
- Sub-module adder_slice (parameter N): combinational N-bit ripple add with cin → {cout, sum}, built from per-bit full-adder equations. Instantiate STAGES times in a generate loop.
- The top level contains only the per-stage pipeline registers, the adv logic and the flag logic.

## Test plan
All cases use WIDTH=32, STAGES=4.
1. Reset/basic latency: after rst release, issue ADD a=0x0000_0001, b=0x0000_0001, cin=0 → out_valid rises exactly 4 cycles after acceptance; sum=0x0000_0002, cout=0, ovf=0, zero=0.
2. Full carry ripple across all segments: ADD a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → sum=0x0000_0000, cout=1, zero=1, ovf=0.
3. Signed overflow and subtract:
   - ADD 0x7FFF_FFFF + 0x0000_0001 → sum=0x8000_0000, ovf=1, cout=0.
   - SUB 0x8000_0000 − 0x0000_0001, cin=0 → sum=0x7FFF_FFFF, ovf=1, cout=1.
   - SUB 0x0000_0003 − 0x0000_0005 → sum=0xFFFF_FFFE, cout=0, ovf=0.
4. Back-pressure: stream 8 random beats with out_ready toggling pseudo-randomly → results match a reference model in order; in_ready=0 in every cycle with out_valid && !out_ready; outputs stable throughout each stall.
5. Bubbles plus full throughput: alternate in_valid 1,0,1,1,1 with out_ready=1 → out_valid pattern equals the input pattern delayed by 4 cycles.
6. Mid-stream reset: 3 beats in flight, then pulse rst for 1 cycle → out_valid=0 immediately and no stale result emerges; the next accepted beat emerges 4 cycles later.
